// File: rtl/ssp_txfifo.sv
// ssp_txfifo: transmit byte FIFO between the APB slave decode and the serial
// transmit engine. The APB side pushes with PSEL & PWRITE. The engine pops the
// head byte through a valid/ready handshake.
// Latency: a push into an empty FIFO is visible on TxData/tx_valid one edge later.
// Backpressure: a push while full (and no pop in the same cycle) is dropped.
//
// Ports:
//   PCLK       clock, all state changes on the rising edge
//   CLEAR      synchronous active-high reset, overrides any push/pop that cycle
//   PSEL       APB select
//   PWRITE     APB write strobe; PSEL & PWRITE requests a push
//   PWDATA     byte to push
//   tx_ready   engine accepts the head byte this cycle
//   TxData     registered head-of-FIFO byte
//   tx_valid   registered, TxData holds a valid byte
//   SSPTXINTR  refill request, occupancy <= DEPTH/2
//   tx_level   current occupancy, 0..DEPTH
//   tx_overrun sticky overrun flag, present only with SSP_TXFIFO_OVERRUN_EN
//
// Optional feature macro: SSP_TXFIFO_OVERRUN_EN

module ssp_txfifo #(
   parameter int DEPTH = 4,
   parameter int DW    = 8,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          PCLK,
   input  logic          CLEAR,
   input  logic          PSEL,
   input  logic          PWRITE,
   input  logic [DW-1:0] PWDATA,
   input  logic          tx_ready,
   output logic [DW-1:0] TxData,
   output logic          tx_valid,
   output logic          SSPTXINTR,
   output logic [CW-1:0] tx_level
`ifdef SSP_TXFIFO_OVERRUN_EN
   ,
   output logic          tx_overrun
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
   localparam logic [CW-1:0] HALF_LVL = CW'(DEPTH / 2);
   localparam logic [CW-1:0] ONE_LVL  = CW'(1);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;

   logic          push_req;
   logic          pop;
   logic          push_acc;
   logic [AW-1:0] rd_nxt;
   logic [CW-1:0] count_nxt;
   logic [DW-1:0] txdata_nxt;
   logic          tx_valid_nxt;

   assign push_req = PSEL & PWRITE;
   assign pop      = tx_valid & tx_ready;
   // A pop frees a slot in the same cycle, so a full FIFO still takes a push.
   assign push_acc = push_req & ((count < FULL_LVL) | pop);
   assign rd_nxt   = rd_ptr + AW'(1);

   always_comb begin
      count_nxt = count;
      case ({push_acc, pop})
         2'b10:   count_nxt = count + ONE_LVL;
         2'b01:   count_nxt = count - ONE_LVL;
         default: count_nxt = count;
      endcase
   end

   // The head register is loaded from the next entry or straight from PWDATA.
   // This avoids a bubble cycle when the FIFO is empty or down to its last entry.
   always_comb begin
      txdata_nxt   = TxData;
      tx_valid_nxt = tx_valid;
      if (pop) begin
         if (count > ONE_LVL) begin
            txdata_nxt   = mem[rd_nxt];
            tx_valid_nxt = 1'b1;
         end else if (push_acc) begin
            txdata_nxt   = PWDATA;
            tx_valid_nxt = 1'b1;
         end else begin
            tx_valid_nxt = 1'b0;     // last byte leaves; TxData keeps its value
         end
      end else if (push_acc && (count == '0)) begin
         txdata_nxt   = PWDATA;
         tx_valid_nxt = 1'b1;
      end
   end

   always_ff @(posedge PCLK) begin
      if (CLEAR) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         TxData   <= '0;
         tx_valid <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push_acc) begin
            mem[wr_ptr] <= PWDATA;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_nxt;
         end
         count    <= count_nxt;
         TxData   <= txdata_nxt;
         tx_valid <= tx_valid_nxt;
      end
   end

   assign tx_level  = count;
   assign SSPTXINTR = (count <= HALF_LVL);

`ifdef SSP_TXFIFO_OVERRUN_EN
   always_ff @(posedge PCLK) begin
      if (CLEAR) begin
         tx_overrun <= 1'b0;
      end else if (push_req && (count == FULL_LVL) && !pop) begin
         tx_overrun <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_ssp_txfifo.sv
// tb_ssp_txfifo: self-checking bench for ssp_txfifo using a byte scoreboard.
// Expected bytes are queued when a push is accepted and compared on each pop.
// The queue size is the reference occupancy for tx_level, tx_valid and SSPTXINTR.

module tb_ssp_txfifo;

   logic       PCLK;
   logic       CLEAR;
   logic       PSEL;
   logic       PWRITE;
   logic [7:0] PWDATA;
   logic       tx_ready;
   logic [7:0] TxData;
   logic       tx_valid;
   logic       SSPTXINTR;
   logic [2:0] tx_level;
`ifdef SSP_TXFIFO_OVERRUN_EN
   logic       tx_overrun;
   logic       exp_ovr;
`endif

   int         n_checks;
   int         n_errors;
   logic [7:0] exp_q [$];
   logic [7:0] last_dat;

   ssp_txfifo #(.DEPTH(4), .DW(8)) dut (
      .PCLK      (PCLK),
      .CLEAR     (CLEAR),
      .PSEL      (PSEL),
      .PWRITE    (PWRITE),
      .PWDATA    (PWDATA),
      .tx_ready  (tx_ready),
      .TxData    (TxData),
      .tx_valid  (tx_valid),
      .SSPTXINTR (SSPTXINTR),
      .tx_level  (tx_level)
`ifdef SSP_TXFIFO_OVERRUN_EN
      ,
      .tx_overrun(tx_overrun)
`endif
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Compare all outputs against the reference state after an edge.
   task automatic check_state(input string tag);
      int sz;
      sz = exp_q.size();
      check({tag, "_level"}, 32'(tx_level), 32'(sz));
      check({tag, "_valid"}, 32'(tx_valid), 32'(sz > 0));
      check({tag, "_intr"},  32'(SSPTXINTR), 32'(sz <= 2));
      if (sz > 0) check({tag, "_head"}, 32'(TxData), 32'(exp_q[0]));
      else        check({tag, "_hold"}, 32'(TxData), 32'(last_dat));
`ifdef SSP_TXFIFO_OVERRUN_EN
      check({tag, "_ovr"}, 32'(tx_overrun), 32'(exp_ovr));
`endif
   endtask

   // Drive one cycle. The scoreboard decides pop/accept from its own occupancy.
   task automatic step(input string tag, input logic psel, input logic pwr,
                       input logic [7:0] d, input logic rdy);
      int   sz;
      logic pop_m;
      logic acc_m;
      PSEL     = psel;
      PWRITE   = pwr;
      PWDATA   = d;
      tx_ready = rdy;
      sz    = exp_q.size();
      pop_m = (sz > 0) && rdy;
      acc_m = psel && pwr && ((sz < 4) || pop_m);
`ifdef SSP_TXFIFO_OVERRUN_EN
      if (psel && pwr && (sz == 4) && !pop_m) exp_ovr = 1'b1;
`endif
      if (pop_m) begin
         check({tag, "_popdat"}, 32'(TxData), 32'(exp_q[0]));
         last_dat = exp_q.pop_front();
      end
      if (acc_m) begin
         if (sz == 0 || (sz == 1 && pop_m)) last_dat = d;
         exp_q.push_back(d);
      end
      @(posedge PCLK);
      #1;
      check_state(tag);
   endtask

   task automatic do_clear(input int cycles, input logic psel, input logic [7:0] d,
                           input logic rdy);
      CLEAR    = 1'b1;
      PSEL     = psel;
      PWRITE   = psel;
      PWDATA   = d;
      tx_ready = rdy;
      repeat (cycles) @(posedge PCLK);
      #1;
      CLEAR = 1'b0;
      PSEL  = 1'b0;
      PWRITE = 1'b0;
      tx_ready = 1'b0;
      exp_q.delete();
      last_dat = 8'h00;
`ifdef SSP_TXFIFO_OVERRUN_EN
      exp_ovr = 1'b0;
`endif
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 6; i++) step(tag, 1'b0, 1'b0, 8'h00, 1'b1);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      last_dat = 8'h00;
      CLEAR    = 1'b1;
      PSEL     = 1'b0;
      PWRITE   = 1'b0;
      PWDATA   = 8'h00;
      tx_ready = 1'b0;
`ifdef SSP_TXFIFO_OVERRUN_EN
      exp_ovr  = 1'b0;
`endif

      // reset / idle
      do_clear(2, 1'b0, 8'h00, 1'b0);
      check_state("rst");
      check("rst_data", 32'(TxData), 32'h00);

      // single byte latency, last pop holds TxData
      step("single_push", 1'b1, 1'b1, 8'hA5, 1'b0);
      check("single_data", 32'(TxData), 32'hA5);
      step("single_pop", 1'b0, 1'b0, 8'h00, 1'b1);
      check("single_hold", 32'(TxData), 32'hA5);

      // PSEL without PWRITE does nothing
      step("read_only", 1'b1, 1'b0, 8'hCC, 1'b0);

      // fill, overflow, in-order drain
      step("fill1", 1'b1, 1'b1, 8'h11, 1'b0);
      step("fill2", 1'b1, 1'b1, 8'h22, 1'b0);
      step("fill3", 1'b1, 1'b1, 8'h33, 1'b0);
      check("fill3_intr", 32'(SSPTXINTR), 32'h0);
      step("fill4", 1'b1, 1'b1, 8'h44, 1'b0);
      step("ovf", 1'b1, 1'b1, 8'h55, 1'b0);
      check("ovf_level", 32'(tx_level), 32'h4);
      drain("drain1");

      // simultaneous push/pop at full
      step("f1", 1'b1, 1'b1, 8'h01, 1'b0);
      step("f2", 1'b1, 1'b1, 8'h02, 1'b0);
      step("f3", 1'b1, 1'b1, 8'h03, 1'b0);
      step("f4", 1'b1, 1'b1, 8'h04, 1'b0);
      step("full_pp", 1'b1, 1'b1, 8'h99, 1'b1);
      check("full_pp_data", 32'(TxData), 32'h02);
      drain("drain2");

      // simultaneous push/pop at count 1
      step("one_push", 1'b1, 1'b1, 8'h77, 1'b0);
      step("one_pp", 1'b1, 1'b1, 8'h88, 1'b1);
      check("one_pp_data", 32'(TxData), 32'h88);
      drain("drain3");

      // wrap-around: 10 push/pop pairs
      for (int i = 0; i < 10; i++) step("wrap", 1'b1, 1'b1, 8'(8'h30 + i), 1'b1);
      drain("drain4");

      // reset mid-operation with push and pop in the same cycle
      step("mid1", 1'b1, 1'b1, 8'hA1, 1'b0);
      step("mid2", 1'b1, 1'b1, 8'hA2, 1'b0);
      step("mid3", 1'b1, 1'b1, 8'hA3, 1'b0);
      do_clear(1, 1'b1, 8'hEE, 1'b1);
      check_state("mid_clr");
      check("mid_clr_data", 32'(TxData), 32'h00);
      step("after_clr", 1'b1, 1'b1, 8'h5A, 1'b0);
      check("after_clr_data", 32'(TxData), 32'h5A);
      drain("drain5");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/ssp_txfifo.md
Name: ssp_txfifo

Overview:
- Transmit-side FIFO of the SSP block, the counterpart of the receive FIFO.
- The APB side pushes bytes with PSEL & PWRITE. The transmit shift logic pops bytes through a valid/ready handshake.
- SSPTXINTR requests refill when the FIFO is half empty or emptier.
- Sits between the APB slave decode and the serial transmit engine.

Parameters:
DEPTH, 4, number of byte entries; power of two, >= 2
DW, 8, data width in bits
CW, $clog2(DEPTH)+1, width of the occupancy counter (derived; do not override)

Ports:
PCLK  input  1  clock; all state changes on rising edge
CLEAR  input  1  synchronous active-high reset
PSEL  input  1  APB select
PWRITE  input  1  APB write strobe; a push is requested when PSEL & PWRITE
PWDATA  input  DW  byte to push
tx_ready  input  1  transmit engine accepts the head byte this cycle
TxData  output  DW  head-of-FIFO byte, registered
tx_valid  output  1  TxData holds a valid byte, registered
SSPTXINTR  output  1  transmit interrupt: occupancy <= DEPTH/2
tx_level  output  CW  current occupancy, 0..DEPTH

Behaviour:
- Storage: mem[DEPTH] of DW bits, wr_ptr and rd_ptr of log2(DEPTH) bits (wrap modulo DEPTH), count of CW bits. tx_level = count.
- CLEAR=1 at an edge:
  - wr_ptr, rd_ptr and count go to 0; TxData goes to 0; tx_valid goes to 0; mem contents go to 0.
  - CLEAR has priority over any simultaneous push or pop; the push and pop are discarded.
  - After reset, SSPTXINTR=1 and tx_level=0.
- push_req = PSEL & PWRITE.
- pop = tx_valid & tx_ready. A pop with tx_valid=0 is ignored.
- Push is accepted when push_req & (count < DEPTH | pop).
  - An accepted push writes mem[wr_ptr] <= PWDATA and increments wr_ptr.
- Pop increments rd_ptr.
- count update: next count = count + accepted push - pop. Simultaneous push and pop leaves count unchanged, including when count=DEPTH.
- Head register: TxData/tx_valid always mirror mem[rd_ptr] after the edge, with no bubble.
  - Push into an empty FIFO at edge N: TxData=PWDATA and tx_valid=1 immediately after edge N. Latency is one edge.
  - Pop with count>1: TxData <= mem[rd_ptr+1] at the same edge.
  - Pop with count=1 and no push: tx_valid <= 0 and TxData holds its last value.
  - Pop with count=1 and simultaneous push: TxData <= PWDATA and tx_valid stays 1.
- Push when full without a pop: data is dropped; no pointer or count change; mem is unmodified.
- SSPTXINTR = (count <= DEPTH/2). It is decoded from the registered count, so it is glitch-free and tracks tx_level.
- PSEL & ~PWRITE has no effect on this block.
- Byte order out equals push order. No byte is duplicated or lost, except pushes dropped when full.

Optional Feature:
- Macro: SSP_TXFIFO_OVERRUN_EN.
- Defined:
  - Adds output port tx_overrun (1 bit, registered, reset 0).
  - tx_overrun is set at any edge where push_req=1, count=DEPTH and pop=0.
  - It is sticky and cleared only by CLEAR.
  - Width of tx_level and all other behaviour unchanged.
- Undefined: the port and its logic are absent; dropped pushes are silent.

Test Plan:
- Reset/idle: assert CLEAR for 2 cycles, then release -> tx_valid=0, TxData=0x00, tx_level=0, SSPTXINTR=1.
- Single-byte latency: push 0xA5 with tx_ready=0 -> next cycle tx_valid=1, TxData=0xA5, tx_level=1; pulse tx_ready -> tx_valid=0, tx_level=0.
- Fill, overflow and order:
  - With tx_ready=0, push 0x11, 0x22, 0x33, 0x44, 0x55 -> tx_level=4, SSPTXINTR=0 after the third push.
  - 0x55 is dropped; tx_overrun=1 when SSP_TXFIFO_OVERRUN_EN is defined.
  - Drain with tx_ready=1 -> TxData sequence 0x11, 0x22, 0x33, 0x44, then tx_valid=0. SSPTXINTR returns to 1 when tx_level=2.
- Simultaneous push/pop: at full (0x01..0x04), push 0x99 with tx_ready=1 -> tx_level stays 4, TxData=0x02. Draining yields 0x02, 0x03, 0x04, 0x99. At count=1 with head 0x77, push 0x88 and pop together -> TxData=0x88, tx_valid stays 1.
- Wrap-around: perform 10 push/pop pairs of 0x30..0x39 -> all 10 bytes emerge in order; pointers wrap at 4 with no corruption.
- Reset mid-operation: with 3 bytes queued, assert CLEAR in the same cycle as a push of 0xEE and a pop -> after the edge tx_level=0, tx_valid=0, tx_overrun=0; the next push of 0x5A appears as TxData=0x5A.
